// File: rtl/pcpi_mul_arbiter_if.sv
// Bundle of the two requester PCPI ports, the shared multiplier PCPI port and the
// watchdog pulse; "slave" is the arbiter's view, "master" is the surrounding system.
interface pcpi_mul_arbiter_if;
    logic        r0_valid;
    logic [31:0] r0_insn;
    logic [31:0] r0_rs1;
    logic [31:0] r0_rs2;
    logic        r0_wr;
    logic [31:0] r0_rd;
    logic        r0_wait;
    logic        r0_ready;

    logic        r1_valid;
    logic [31:0] r1_insn;
    logic [31:0] r1_rs1;
    logic [31:0] r1_rs2;
    logic        r1_wr;
    logic [31:0] r1_rd;
    logic        r1_wait;
    logic        r1_ready;

    logic        m_valid;
    logic [31:0] m_insn;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic        m_wr;
    logic        m_ready;
    logic [31:0] m_rd;

    logic        err_timeout;

    modport slave (
        input  r0_valid, r0_insn, r0_rs1, r0_rs2,
        output r0_wr, r0_rd, r0_wait, r0_ready,
        input  r1_valid, r1_insn, r1_rs1, r1_rs2,
        output r1_wr, r1_rd, r1_wait, r1_ready,
        output m_valid, m_insn, m_rs1, m_rs2,
        input  m_wr, m_ready, m_rd,
        output err_timeout
    );

    modport master (
        output r0_valid, r0_insn, r0_rs1, r0_rs2,
        input  r0_wr, r0_rd, r0_wait, r0_ready,
        output r1_valid, r1_insn, r1_rs1, r1_rs2,
        input  r1_wr, r1_rd, r1_wait, r1_ready,
        input  m_valid, m_insn, m_rs1, m_rs2,
        output m_wr, m_ready, m_rd,
        input  err_timeout
    );
endinterface

// File: rtl/pcpi_mul_arbiter.sv
// Two-requester round-robin arbiter sharing one PCPI multiplier, with abort drain,
// one-cycle re-issue guard and a per-operation watchdog.
module pcpi_mul_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    pcpi_mul_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

    function automatic logic mul_eligible(input logic valid, input logic [31:0] insn);
        return valid && (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) && !insn[14];
    endfunction

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        elig0_s, elig1_s, own_valid_s, resp_s, timeout_s, busy_s;
    logic [31:0] own_insn_s, own_rs1_s, own_rs2_s;

    assign elig0_s     = mul_eligible(bus.r0_valid, bus.r0_insn);
    assign elig1_s     = mul_eligible(bus.r1_valid, bus.r1_insn);
    assign own_valid_s = owner_q ? bus.r1_valid : bus.r0_valid;
    assign own_insn_s  = owner_q ? bus.r1_insn  : bus.r0_insn;
    assign own_rs1_s   = owner_q ? bus.r1_rs1   : bus.r0_rs1;
    assign own_rs2_s   = owner_q ? bus.r1_rs2   : bus.r0_rs2;
    assign busy_s      = (state_q == S_BUSY);

    // Next-state logic: arbitration, response capture, abort drain and watchdog.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        resp_s    = 1'b0;
        timeout_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (elig0_s && elig1_s) begin
                    owner_d = ~last_q;
                    state_d = S_BUSY;
                end else if (elig0_s) begin
                    owner_d = 1'b0;
                    state_d = S_BUSY;
                end else if (elig1_s) begin
                    owner_d = 1'b1;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (bus.m_ready) begin
                    resp_s  = 1'b1;
                    last_d  = owner_q;
                    state_d = S_FLUSH;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_s = 1'b1;
                    state_d   = S_FLUSH;
                end else if (!own_valid_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DRAIN: begin
                // The abandoned operation's response is swallowed here, never forwarded.
                cnt_d = cnt_q + 8'd1;
                if (bus.m_ready) begin
                    state_d = S_FLUSH;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_s = 1'b1;
                    state_d   = S_FLUSH;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; last resets to 1 so r0 wins the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode; gated by resetn so every output drops the moment reset asserts.
    always_comb begin
        bus.m_valid     = resetn && busy_s;
        bus.m_insn      = bus.m_valid ? own_insn_s : 32'd0;
        bus.m_rs1       = bus.m_valid ? own_rs1_s  : 32'd0;
        bus.m_rs2       = bus.m_valid ? own_rs2_s  : 32'd0;
        bus.r0_ready    = resetn && resp_s && !owner_q;
        bus.r1_ready    = resetn && resp_s && owner_q;
        bus.r0_wr       = bus.r0_ready && bus.m_wr;
        bus.r1_wr       = bus.r1_ready && bus.m_wr;
        bus.r0_rd       = bus.r0_ready ? bus.m_rd : 32'd0;
        bus.r1_rd       = bus.r1_ready ? bus.m_rd : 32'd0;
        bus.r0_wait     = resetn && elig0_s && !bus.r0_ready;
        bus.r1_wait     = resetn && elig1_s && !bus.r1_ready;
        bus.err_timeout = resetn && timeout_s;
    end
endmodule

// File: tb/tb_pcpi_mul_arbiter.sv
// Directed cycle tables plus a result scoreboard against a two-cycle behavioural multiplier.
module tb_pcpi_mul_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    pcpi_mul_arbiter_if bus ();

    pcpi_mul_arbiter #(.TIMEOUT(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] rd;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Behavioural single-stage multiplier: latches the request, answers two cycles after valid.
    logic        mul_en = 1'b1;
    logic        mul_busy = 1'b0;
    logic [31:0] mul_res = 32'd0;
    logic        mr_q = 1'b0;
    logic        mwr_q = 1'b0;
    logic [31:0] mrd_q = 32'd0;
    assign bus.m_ready = mr_q;
    assign bus.m_wr    = mwr_q;
    assign bus.m_rd    = mrd_q;

    function automatic logic [31:0] mul_ref(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return (insn[13:12] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    always @(posedge clk) begin
        mr_q  <= 1'b0;
        mwr_q <= 1'b0;
        mrd_q <= 32'd0;
        if (mul_busy) begin
            mul_busy <= 1'b0;
            if (mul_en) begin
                mr_q  <= 1'b1;
                mwr_q <= 1'b1;
                mrd_q <= mul_res;
            end
        end else if (bus.m_valid && !bus.m_ready) begin
            mul_busy <= 1'b1;
            mul_res  <= mul_ref(bus.m_insn, bus.m_rs1, bus.m_rs2);
        end
    end

    // Scoreboard: every ready pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (bus.r0_ready || bus.r1_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ready", 32'(bus.r1_ready), 32'(bus.r0_ready));
            end else begin
                e = sb_q.pop_front();
                chk("sb_id", 32'(bus.r1_ready), 32'(e.id));
                chk("sb_single", 32'(bus.r0_ready & bus.r1_ready), 32'd0);
                chk("sb_wr", 32'(bus.r1_ready ? bus.r1_wr : bus.r0_wr), 32'd1);
                chk("sb_rd", bus.r1_ready ? bus.r1_rd : bus.r0_rd, e.rd);
            end
        end
    end

    task automatic set_req(input logic sel, input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        if (!sel) begin
            bus.r0_valid = 1'b1; bus.r0_insn = insn; bus.r0_rs1 = a; bus.r0_rs2 = b;
        end else begin
            bus.r1_valid = 1'b1; bus.r1_insn = insn; bus.r1_rs1 = a; bus.r1_rs2 = b;
        end
    endtask

    task automatic expect_cyc(input string t, input int c, input logic [15:0] mv, input logic [15:0] w0,
                              input logic [15:0] w1, input logic [15:0] rd0, input logic [15:0] rd1,
                              input logic [15:0] to);
        chk($sformatf("%s_c%0d_m_valid", t, c), 32'(bus.m_valid), 32'(mv[c]));
        chk($sformatf("%s_c%0d_r0_wait", t, c), 32'(bus.r0_wait), 32'(w0[c]));
        chk($sformatf("%s_c%0d_r1_wait", t, c), 32'(bus.r1_wait), 32'(w1[c]));
        chk($sformatf("%s_c%0d_r0_ready", t, c), 32'(bus.r0_ready), 32'(rd0[c]));
        chk($sformatf("%s_c%0d_r1_ready", t, c), 32'(bus.r1_ready), 32'(rd1[c]));
        chk($sformatf("%s_c%0d_err_timeout", t, c), 32'(bus.err_timeout), 32'(to[c]));
    endtask

    function automatic logic any_out();
        return |{bus.m_valid, bus.m_insn, bus.m_rs1, bus.m_rs2, bus.r0_wr, bus.r0_rd, bus.r0_wait,
                 bus.r0_ready, bus.r1_wr, bus.r1_rd, bus.r1_wait, bus.r1_ready, bus.err_timeout};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("reset_outputs_zero", 32'(any_out()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] mv, w0, w1, rd0, rd1, to;
        bus.r0_valid = 1'b0; bus.r0_insn = 32'd0; bus.r0_rs1 = 32'd0; bus.r0_rs2 = 32'd0;
        bus.r1_valid = 1'b0; bus.r1_insn = 32'd0; bus.r1_rs1 = 32'd0; bus.r1_rs2 = 32'd0;

        // Reset held with an eligible request present: nothing may leak out.
        set_req(1'b0, mk_insn(3'b000), 32'd7, 32'd6);
        #1;
        chk("reset_hold_outputs_zero", 32'(any_out()), 32'd0);
        bus.r0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Single MUL 7*6 from r0.
        mv = 16'h000E; w0 = 16'h0007; w1 = 16'h0000; rd0 = 16'h0008; rd1 = 16'h0000; to = 16'h0000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                set_req(1'b0, mk_insn(3'b000), 32'd7, 32'd6);
                sb_q.push_back('{id: 1'b0, rd: 32'd42});
            end
            if (c == 4) bus.r0_valid = 1'b0;
            #1;
            expect_cyc("mul", c, mv, w0, w1, rd0, rd1, to);
            if (c == 1) begin
                chk("mul_m_insn", bus.m_insn, mk_insn(3'b000));
                chk("mul_m_rs1", bus.m_rs1, 32'd7);
                chk("mul_m_rs2", bus.m_rs2, 32'd6);
            end
            if (c == 3) begin
                chk("mul_r0_rd", bus.r0_rd, 32'd42);
                chk("mul_r0_wr", 32'(bus.r0_wr), 32'd1);
                chk("mul_r1_rd", bus.r1_rd, 32'd0);
                chk("mul_r1_wr", 32'(bus.r1_wr), 32'd0);
            end
        end

        // Reset mid-BUSY (last=0 here), stale m_ready in IDLE, then tie goes to r0.
        mv = 16'h0E72; w0 = 16'h003B; w1 = 16'h07F8; rd0 = 16'h0040; rd1 = 16'h0800; to = 16'h0000;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c == 0) set_req(1'b0, mk_insn(3'b000), 32'd7, 32'd6);
            if (c == 2) resetn = 1'b0;
            if (c == 3) begin
                resetn = 1'b1;
                set_req(1'b1, mk_insn(3'b000), 32'd5, 32'd5);
                sb_q.push_back('{id: 1'b0, rd: 32'd42});
                sb_q.push_back('{id: 1'b1, rd: 32'd25});
            end
            if (c == 7) bus.r0_valid = 1'b0;
            if (c == 12) bus.r1_valid = 1'b0;
            #1;
            expect_cyc("rst", c, mv, w0, w1, rd0, rd1, to);
            if (c == 2) chk("rst_async_all_zero", 32'(any_out()), 32'd0);
            if (c == 4) chk("rst_tie_owner_rs1", bus.m_rs1, 32'd7);
        end

        // Simultaneous MULHU 0xFFFFFFFF^2 from both after reset.
        do_reset();
        mv = 16'h01CE; w0 = 16'h0007; w1 = 16'h00FF; rd0 = 16'h0008; rd1 = 16'h0100; to = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                set_req(1'b0, mk_insn(3'b011), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
                set_req(1'b1, mk_insn(3'b011), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
                sb_q.push_back('{id: 1'b0, rd: 32'hFFFF_FFFE});
                sb_q.push_back('{id: 1'b1, rd: 32'hFFFF_FFFE});
            end
            if (c == 4) bus.r0_valid = 1'b0;
            if (c == 9) bus.r1_valid = 1'b0;
            #1;
            expect_cyc("tie", c, mv, w0, w1, rd0, rd1, to);
            if (c == 3) chk("tie_r0_rd", bus.r0_rd, 32'hFFFF_FFFE);
            if (c == 8) begin
                chk("tie_r1_rd", bus.r1_rd, 32'hFFFF_FFFE);
                chk("tie_r0_rd_nonowner", bus.r0_rd, 32'd0);
            end
        end

        // DIV from r1 is ineligible.
        mv = 16'h0000; w0 = 16'h0000; w1 = 16'h0000; rd0 = 16'h0000; rd1 = 16'h0000; to = 16'h0000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) set_req(1'b1, mk_insn(3'b100), 32'd100, 32'd7);
            #1;
            expect_cyc("div", c, mv, w0, w1, rd0, rd1, to);
        end
        bus.r1_valid = 1'b0;

        // r0 aborts one cycle into BUSY; the response is drained, pending r1 served after.
        mv = 16'h01C6; w0 = 16'h0003; w1 = 16'h00FF; rd0 = 16'h0000; rd1 = 16'h0100; to = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                set_req(1'b0, mk_insn(3'b000), 32'd3, 32'd5);
                set_req(1'b1, mk_insn(3'b000), 32'd9, 32'd4);
                sb_q.push_back('{id: 1'b1, rd: 32'd36});
            end
            if (c == 2) bus.r0_valid = 1'b0;
            if (c == 9) bus.r1_valid = 1'b0;
            #1;
            expect_cyc("drain", c, mv, w0, w1, rd0, rd1, to);
            if (c == 1) chk("drain_owner_rs1", bus.m_rs1, 32'd3);
            if (c == 6) chk("drain_r1_rs1", bus.m_rs1, 32'd9);
        end

        // Multiplier never answers: watchdog fires on the fourth BUSY cycle.
        mul_en = 1'b0;
        mv = 16'h001E; w0 = 16'h001F; w1 = 16'h0000; rd0 = 16'h0000; rd1 = 16'h0000; to = 16'h0010;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) set_req(1'b0, mk_insn(3'b000), 32'd11, 32'd13);
            if (c == 5) bus.r0_valid = 1'b0;
            #1;
            expect_cyc("tmo", c, mv, w0, w1, rd0, rd1, to);
        end
        mul_en = 1'b1;

        @(negedge clk);
        #3;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pcpi_mul_arbiter.md
PCPI_MUL_ARBITER -- requirements
Module: pcpi_mul_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16 (legal 4..255): the most cycles the arbiter waits for m_ready per operation.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports r0_valid/r1_valid, input, 1, requester n PCPI valid.
REQ-005 SHALL have ports r0_insn/r1_insn, r0_rs1/r1_rs1 and r0_rs2/r1_rs2, input, 32 each, requester n instruction and operands.
REQ-006 SHALL have ports r0_wr/r1_wr, output, 1, requester n write-back strobe.
REQ-007 SHALL have ports r0_rd/r1_rd, output, 32, requester n result.
REQ-008 SHALL have ports r0_wait/r1_wait and r0_ready/r1_ready, output, 1 each, requester n wait and ready.
REQ-009 SHALL have ports m_valid, output, 1, and m_insn/m_rs1/m_rs2, output, 32 each: the shared multiplier's PCPI request.
REQ-010 SHALL have ports m_wr and m_ready, input, 1 each, and m_rd, input, 32: the multiplier response (m_wait ignored).
REQ-011 SHALL have port err_timeout, output, 1, a one-cycle pulse on watchdog expiry.

Function
REQ-012 SHALL treat a request as eligible when rN_valid=1, insn[6:0]=0110011, insn[31:25]=0000001 and insn[14]=0; ineligible requests are never granted and never see wait/ready.
REQ-013 SHALL implement FSM IDLE, BUSY, FLUSH, DRAIN plus registers owner (1b), last (1b) and cnt (8b).
REQ-014 IDLE: with one eligible requester, SHALL register owner=that requester and go to BUSY; with both eligible, SHALL grant !last (round-robin).
REQ-015 BUSY: m_valid=1 and m_insn/m_rs1/m_rs2 SHALL be combinational copies of the owner's inputs; in all other states m_valid=0 and the m_* buses are 0.
REQ-016 BUSY with m_ready=1: SHALL pulse rowner_ready=1 and rowner_wr=m_wr with rowner_rd=m_rd that cycle, set last=owner and go to FLUSH.
REQ-017 FLUSH SHALL last exactly one cycle with m_valid=0 (blocks multiplier re-issue), then go to IDLE; a grant therefore cannot occur earlier than 2 cycles after a ready.
REQ-018 BUSY with rowner_valid=0 (requester abort) and m_ready=0: SHALL go to DRAIN; in DRAIN, m_ready SHALL be absorbed (no rN_ready) and the FSM SHALL then go to FLUSH.
REQ-019 cnt SHALL clear on entering BUSY and increment each BUSY/DRAIN cycle; when cnt reaches TIMEOUT-1 without m_ready, SHALL pulse err_timeout for 1 cycle and go to FLUSH with no rN_ready.
REQ-020 rN_wait SHALL be 1 whenever requester N is eligible and its rN_ready is 0 (queued or in service); it is 0 otherwise.
REQ-021 rN_ready, rN_wr and rN_rd SHALL be 0 except in the REQ-016 cycle for the owner; the non-owner always sees 0.
REQ-022 A requester becoming eligible in the same cycle the other receives ready SHALL wait in IDLE arbitration after FLUSH; no request is dropped.
REQ-023 With an eligible request present, SHALL assert m_valid 1 cycle after IDLE samples it; against the single-stage multiplier, rN_ready follows 3 cycles after valid.

Reset
REQ-024 resetn=0 SHALL immediately force FSM=IDLE, owner=0, last=1 (r0 wins the first tie), cnt=0 and all outputs to 0, including mid-operation; a multiplier response arriving after resetn rises while in IDLE SHALL be ignored.

Verification
REQ-025 r0 MUL (funct3=000), rs1=7, rs2=6, held until ready -> m_valid at cycle 1, r0_ready=r0_wr=1 with r0_rd=42 at cycle 3, r1 outputs remain 0.
REQ-026 r0 and r1 both assert MULHU 0xFFFFFFFF*0xFFFFFFFF in the same cycle after reset -> r0 served first (rd=0xFFFFFFFE), r1 granted 2 cycles after r0_ready and receives 0xFFFFFFFE; r1_wait=1 throughout.
REQ-027 r1 DIV (funct3=100) -> never granted, r1_wait=0, m_valid stays 0.
REQ-028 m_ready tied 0, TIMEOUT=4, r0 MUL issued -> err_timeout pulse at cycle 4 of BUSY, r0_ready never asserted, FSM back in IDLE after FLUSH.
REQ-029 r0 drops valid 1 cycle into BUSY -> DRAIN absorbs the m_ready pulse, no r0_ready, pending r1 request served afterward with correct rd.
REQ-030 resetn pulsed low during BUSY -> all outputs 0 asynchronously; after release, r0 has tie priority and the stale m_ready is ignored.
